// File: rtl/knn_list_ctrl_pkg.sv
// Shared definitions for the KNN ordered-list sequencer and the result/vote logic.
// Holds the FSM state encoding, default list geometry and the index-width helper.
// Optional feature macro used by the top: KNN_CTRL_STATS_EN.
package knn_list_ctrl_pkg;

   localparam int DEF_K      = 8;
   localparam int DEF_COMP_W = 32;
   localparam int DEF_BAG_W  = 32;
   localparam int DEF_CNT_W  = 16;
   localparam int STATE_W    = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   // Width of an index that addresses k list units (at least one bit).
   function automatic int idx_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/knn_list_ctrl_sel.sv
// Registered K:1 selector of one (comp, bag) slice out of the packed list outputs.
// Latency: one cycle from index to data; the index is re-sampled every cycle.
// Data stays stable as long as both the index and the list contents are unchanged.
module knn_list_sel
   import knn_list_ctrl_pkg::*;
#(
   parameter int K      = DEF_K,
   parameter int COMP_W = DEF_COMP_W,
   parameter int BAG_W  = DEF_BAG_W,
   parameter int IDX_W  = idx_width(K)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [IDX_W-1:0]     i_idx,
   input  logic [K*COMP_W-1:0]  i_comp_all,
   input  logic [K*BAG_W-1:0]   i_bag_all,
   output logic [COMP_W-1:0]    o_comp,
   output logic [BAG_W-1:0]     o_bag
);

   logic [COMP_W-1:0] r_comp;
   logic [BAG_W-1:0]  r_bag;

   // Capture the addressed slice of both packed buses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_comp <= '0;
         r_bag  <= '0;
      end else begin
         r_comp <= i_comp_all[32'(i_idx) * COMP_W +: COMP_W];
         r_bag  <= i_bag_all[32'(i_idx) * BAG_W +: BAG_W];
      end
   end

   assign o_comp = r_comp;
   assign o_bag  = r_bag;

endmodule

// File: rtl/knn_list_ctrl.sv
// Query sequencer for the KNN ordered list: clear, stream N candidates in, drain min(N,K) sorted out.
// Insert is combinational from the input handshake; results come out of a one-cycle registered mux.
// out_ready low holds index and data; in_valid low in LOAD stalls. Optional: KNN_CTRL_STATS_EN adds o_hits_cnt.
module knn_list_ctrl
   import knn_list_ctrl_pkg::*;
#(
   parameter int K      = DEF_K,
   parameter int COMP_W = DEF_COMP_W,
   parameter int BAG_W  = DEF_BAG_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [CNT_W-1:0]     i_n_points,
   output logic                 o_busy,
   output logic                 o_done,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [COMP_W-1:0]    i_in_comp,
   input  logic [BAG_W-1:0]     i_in_bag,
   output logic                 o_list_rst,
   output logic                 o_list_valid,
   output logic [COMP_W-1:0]    o_list_comp,
   output logic [BAG_W-1:0]     o_list_bag,
   input  logic [K*COMP_W-1:0]  i_list_comp_all,
   input  logic [K*BAG_W-1:0]   i_list_bag_all,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [COMP_W-1:0]    o_out_comp,
   output logic [BAG_W-1:0]     o_out_bag,
   output logic                 o_out_last
`ifdef KNN_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0]     o_hits_cnt
`endif
);

   localparam int IDX_W = idx_width(K);

   state_t             r_state;
   state_t             w_next;
   logic               r_done;
   logic [CNT_W-1:0]   r_n;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [CNT_W:0]     w_cnt_inc;
   logic [CNT_W-1:0]   w_last_idx;
   logic               w_in_hs;
   logic               w_out_hs;
   logic               w_load_last;
   logic               w_is_last;

   // Handshakes and end-of-phase detection; the accepted count is compared one bit wider so it never wraps.
   assign w_in_hs     = (r_state == ST_LOAD) && i_in_valid;
   assign w_out_hs    = (r_state == ST_OUT) && i_out_ready;
   assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_load_last = w_in_hs && (w_cnt_inc == {1'b0, r_n});
   assign w_last_idx  = (r_n > CNT_W'(K)) ? CNT_W'(K - 1) : (r_n - CNT_W'(1));
   assign w_is_last   = (CNT_W'(r_idx) == w_last_idx);

   // State register; done is raised for the single cycle in which IDLE is re-entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (i_start) w_next = ST_CLEAR;
         ST_CLEAR:  w_next = (r_n != '0) ? ST_LOAD : ST_SETTLE;
         ST_LOAD:   if (w_load_last) w_next = ST_SETTLE;
         ST_SETTLE: w_next = (r_n != '0) ? ST_OUT : ST_IDLE;
         ST_OUT:    if (w_out_hs && w_is_last) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Moore-style control outputs plus the combinational insert path.
   always_comb begin
      o_busy       = (r_state != ST_IDLE);
      o_done       = r_done;
      o_in_ready   = (r_state == ST_LOAD);
      o_list_rst   = (r_state == ST_CLEAR);
      o_list_valid = w_in_hs;
      o_list_comp  = i_in_comp;
      o_list_bag   = i_in_bag;
      o_out_valid  = (r_state == ST_OUT);
      o_out_last   = (r_state == ST_OUT) && w_is_last;
   end

   // Index fed to the selector: zero before draining, advanced on each non-final result handshake.
   always_comb begin
      w_sel_idx = r_idx;
      if (r_state == ST_CLEAR || r_state == ST_SETTLE) begin
         w_sel_idx = '0;
      end else if (w_out_hs && !w_is_last) begin
         w_sel_idx = r_idx + IDX_W'(1);
      end
   end

   // Query length latch, accepted-candidate counter and result index.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_n   <= '0;
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         if (r_state == ST_IDLE && i_start) r_n <= i_n_points;
         if (r_state == ST_CLEAR) begin
            r_cnt <= '0;
         end else if (w_in_hs) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
         end
         r_idx <= w_sel_idx;
      end
   end

`ifdef KNN_CTRL_STATS_EN
   logic [CNT_W-1:0] r_hits;

   // Count accepted candidates that beat the current worst stored entry, i.e. that enter the list.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hits <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_hits <= '0;
      end else if (w_in_hs && (i_in_comp < i_list_comp_all[(K-1)*COMP_W +: COMP_W]) && (r_hits != '1)) begin
         r_hits <= r_hits + CNT_W'(1);
      end
   end

   assign o_hits_cnt = r_hits;
`endif

   knn_list_sel #(
      .K      (K),
      .COMP_W (COMP_W),
      .BAG_W  (BAG_W),
      .IDX_W  (IDX_W)
   ) u_sel (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_idx      (w_sel_idx),
      .i_comp_all (i_list_comp_all),
      .i_bag_all  (i_list_bag_all),
      .o_comp     (o_out_comp),
      .o_bag      (o_out_bag)
   );

endmodule

// File: tb/tb_knn_list_ctrl.sv
// Bench for knn_list_ctrl: models the K-entry ordered list the controller drives, and predicts the
// result stream by ranking the candidates of each query directly (stable on equal distances).
// Build with KNN_CTRL_STATS_EN defined to also check the hit counter.
module tb_knn_list_ctrl;
   localparam int K      = 8;
   localparam int COMP_W = 32;
   localparam int BAG_W  = 32;
   localparam int CNT_W  = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [CNT_W-1:0]   n_points = '0;
   logic               busy, done;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [COMP_W-1:0]  in_comp = '0;
   logic [BAG_W-1:0]   in_bag = '0;
   logic               list_rst, list_valid;
   logic [COMP_W-1:0]  list_comp;
   logic [BAG_W-1:0]   list_bag;
   logic [K*COMP_W-1:0] list_comp_all;
   logic [K*BAG_W-1:0]  list_bag_all;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [COMP_W-1:0]  out_comp;
   logic [BAG_W-1:0]   out_bag;
   logic               out_last;
`ifdef KNN_CTRL_STATS_EN
   logic [CNT_W-1:0]   hits_cnt;
`endif

   knn_list_ctrl #(.K(K), .COMP_W(COMP_W), .BAG_W(BAG_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_points(n_points),
      .o_busy(busy), .o_done(done),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_comp(in_comp), .i_in_bag(in_bag),
      .o_list_rst(list_rst), .o_list_valid(list_valid), .o_list_comp(list_comp), .o_list_bag(list_bag),
      .i_list_comp_all(list_comp_all), .i_list_bag_all(list_bag_all),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_comp(out_comp), .o_out_bag(out_bag),
      .o_out_last(out_last)
`ifdef KNN_CTRL_STATS_EN
      , .o_hits_cnt(hits_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- ordered-list environment (K insertion units) ----------------
   logic [COMP_W-1:0] lst_c [K];
   logic [BAG_W-1:0]  lst_b [K];

   initial begin
      for (int i = 0; i < K; i++) begin lst_c[i] = 32'hdead0000 + i; lst_b[i] = 32'hbeef; end
   end

   always @(posedge clk) begin
      if (list_rst) begin
         for (int i = 0; i < K; i++) begin lst_c[i] <= '1; lst_b[i] <= '0; end
      end else if (list_valid) begin
         int p;
         p = K;
         for (int i = K - 1; i >= 0; i--) if (lst_c[i] > list_comp) p = i;
         for (int i = K - 1; i > 0; i--) if (i > p) begin lst_c[i] <= lst_c[i-1]; lst_b[i] <= lst_b[i-1]; end
         if (p < K) begin lst_c[p] <= list_comp; lst_b[p] <= list_bag; end
      end
   end

   always_comb begin
      for (int i = 0; i < K; i++) begin
         list_comp_all[i*COMP_W +: COMP_W] = lst_c[i];
         list_bag_all[i*BAG_W +: BAG_W]   = lst_b[i];
      end
   end

   // ---------------- scoreboard state ----------------
   int     n_asserts = 0;
   int     n_fail = 0;
   longint cand_c[$], cand_b[$];
   longint exp_c[K], exp_b[K];
   longint obs_c[$], obs_b[$];
   int     exp_m = 0, pos = 0, done_cnt = 0, lrst_cnt = 0, exp_hits = 0;
   bit     chk_en = 1'b0, rdy_toggle = 1'b0, prev_stall = 1'b0;
   longint prev_c = 0, prev_b = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_asserts++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Ready pattern: constantly high, or alternating 1/0 every cycle.
   initial forever begin
      @(negedge clk);
      out_ready = rdy_toggle ? !out_ready : 1'b1;
   end

   // Per-cycle compare of the DUT against the expected result stream.
   initial forever begin
      @(negedge clk); #1;
      if (chk_en && !rst) begin
         if (done) begin done_cnt++; chk("done_with_idle", busy, 0); end
         if (list_rst) lrst_cnt++;
         chk("list_valid_gate", list_valid, in_valid && in_ready);
         chk("out_valid_bound", out_valid && (pos >= exp_m), 0);
         if (prev_stall) begin
            chk("stall_valid_hold", out_valid, 1);
            chk("stall_comp_hold", out_comp, prev_c);
            chk("stall_bag_hold", out_bag, prev_b);
         end
         prev_stall = 1'b0;
         if (out_valid && pos < exp_m) begin
            chk("out_comp", out_comp, exp_c[pos]);
            chk("out_bag", out_bag, exp_b[pos]);
            chk("out_last", out_last, pos == exp_m - 1);
            if (out_ready) begin
               obs_c.push_back(out_comp); obs_b.push_back(out_bag); pos++;
            end else begin
               prev_stall = 1'b1; prev_c = out_comp; prev_b = out_bag;
            end
         end
      end
   end

   // Predict results by rank: strictly smaller distances, then earlier arrivals of equal distance.
   task automatic prep();
      int n;
      n = cand_c.size();
      exp_m = (n < K) ? n : K;
      for (int i = 0; i < n; i++) begin
         int r;
         r = 0;
         for (int j = 0; j < n; j++)
            if (cand_c[j] < cand_c[i] || (cand_c[j] == cand_c[i] && j < i)) r++;
         if (r < K) begin exp_c[r] = cand_c[i]; exp_b[r] = cand_b[i]; end
      end
      exp_hits = 0;
      for (int i = 0; i < n; i++) begin
         longint prev[$];
         longint thr;
         for (int j = 0; j < i; j++) prev.push_back(cand_c[j]);
         prev.sort();
         thr = (i < K) ? 64'hFFFFFFFF : prev[K-1];
         if (cand_c[i] < thr) exp_hits++;
      end
      pos = 0; done_cnt = 0; lrst_cnt = 0; prev_stall = 1'b0;
      obs_c.delete(); obs_b.delete();
      chk_en = 1'b1;
   endtask

   task automatic start_and_load(input bit gaps, input bit poke);
      int n, i, cyc;
      n = cand_c.size();
      prep();
      @(negedge clk);
      start = 1'b1; n_points = CNT_W'(n);
      in_valid = 1'b1; in_comp = 32'd999; in_bag = 32'd999;
      @(negedge clk);
      start = 1'b0;
      i = 0; cyc = 0;
      while (i < n && cyc < 1000) begin
         in_comp = COMP_W'(cand_c[i]); in_bag = BAG_W'(cand_b[i]);
         in_valid = !(gaps && (cyc % 3 == 1));
         start = poke && (cyc == 2);
         n_points = (poke && cyc == 2) ? CNT_W'(1) : CNT_W'(n);
         #1;
         if (in_valid && in_ready) i++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; n_points = CNT_W'(n);
      chk("load_accepted", i, n);
      // Left asserted with a tiny distance: any insert outside LOAD would surface in the results.
      in_valid = 1'b1; in_comp = '0; in_bag = 32'd777;
   endtask

   task automatic finish_query();
      int c;
      c = 0;
      while (done_cnt == 0 && c < 2000) begin @(negedge clk); c++; end
      chk("done_within_budget", c < 2000, 1);
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("results_emitted", pos, exp_m);
      chk("list_rst_pulses", lrst_cnt, 1);
      chk("idle_busy", busy, 0);
`ifdef KNN_CTRL_STATS_EN
      chk("hits_cnt", hits_cnt, exp_hits);
`endif
   endtask

   task automatic set_cands(input int n, input int cs[16], input int bs[16]);
      cand_c.delete(); cand_b.delete();
      for (int i = 0; i < n; i++) begin cand_c.push_back(cs[i]); cand_b.push_back(bs[i]); end
   endtask

   initial begin
      int cs[16], bs[16];
      int lit_c[8], lit_b[8];
      int c;

      // Reset values while rst is held.
      #2;
      chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0); chk("rst_list_rst", list_rst, 0);
      chk("rst_list_valid", list_valid, 0); chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // N=5, unordered distances; a start pulse during LOAD must be ignored.
      cs = '{40,10,30,20,50,0,0,0,0,0,0,0,0,0,0,0};
      bs = '{0,1,2,3,4,0,0,0,0,0,0,0,0,0,0,0};
      set_cands(5, cs, bs);
      start_and_load(1'b0, 1'b1);
      finish_query();
      lit_c = '{10,20,30,40,50,0,0,0};
      lit_b = '{1,3,2,0,4,0,0,0};
      chk("q1_count", obs_c.size(), 5);
      for (int i = 0; i < 5; i++) if (i < obs_c.size()) begin
         chk("q1_lit_comp", obs_c[i], lit_c[i]);
         chk("q1_lit_bag", obs_b[i], lit_b[i]);
      end

      // N=12 > K, descending distances: only the 8 smallest come out.
      for (int i = 0; i < 12; i++) begin cs[i] = 12 - i; bs[i] = i; end
      set_cands(12, cs, bs);
      start_and_load(1'b0, 1'b0);
      finish_query();
      chk("q2_count", obs_c.size(), 8);
      for (int i = 0; i < 8; i++) if (i < obs_c.size()) begin
         chk("q2_lit_comp", obs_c[i], i + 1);
         chk("q2_lit_bag", obs_b[i], 11 - i);
      end

      // N=0: clear, settle, done; no results.
      set_cands(0, cs, bs);
      start_and_load(1'b0, 1'b0);
      finish_query();
      chk("q3_no_results", obs_c.size(), 0);

      // N=4 with duplicate distances, input gaps and a toggling out_ready.
      cs = '{7,3,7,3,0,0,0,0,0,0,0,0,0,0,0,0};
      bs = '{0,1,2,3,0,0,0,0,0,0,0,0,0,0,0,0};
      set_cands(4, cs, bs);
      rdy_toggle = 1'b1;
      start_and_load(1'b1, 1'b0);
      finish_query();
      rdy_toggle = 1'b0;
      chk("q4_first_bag", (obs_b.size() > 0) ? obs_b[0] : -1, 1);
      chk("q4_third_bag", (obs_b.size() > 2) ? obs_b[2] : -1, 0);

      // Reset while emitting the third result, then a fresh N=3 query.
      cs = '{60,20,50,10,40,30,0,0,0,0,0,0,0,0,0,0};
      bs = '{0,1,2,3,4,5,0,0,0,0,0,0,0,0,0,0};
      set_cands(6, cs, bs);
      start_and_load(1'b0, 1'b0);
      c = 0;
      while (!(out_valid && out_comp == 32'd30) && c < 500) begin @(negedge clk); #2; c++; end
      chk("rst_test_reached_idx2", c < 500, 1);
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("postrst_busy", busy, 0);
      cs = '{300,100,200,0,0,0,0,0,0,0,0,0,0,0,0,0};
      bs = '{7,8,9,0,0,0,0,0,0,0,0,0,0,0,0,0};
      set_cands(3, cs, bs);
      start_and_load(1'b0, 1'b0);
      finish_query();
      chk("q5_count", obs_c.size(), 3);
      chk("q5_first_comp", (obs_c.size() > 0) ? obs_c[0] : -1, 100);

`ifdef KNN_CTRL_STATS_EN
      // Ascending 1..10 into K=8: the last two cannot beat the stored worst entry.
      for (int i = 0; i < 10; i++) begin cs[i] = i + 1; bs[i] = i; end
      set_cands(10, cs, bs);
      start_and_load(1'b0, 1'b0);
      finish_query();
      chk("stats_lit_hits", hits_cnt, 8);
      repeat (3) @(negedge clk);
      chk("stats_hold_after_done", hits_cnt, 8);
`endif

      in_valid = 1'b0;
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   // Absolute guard against a hung run.
   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
